sa_tile_sequencer: RTL and testbench

Tile-level sequencer that sits directly upstream of `systolic_array_controller`. It walks a programmed number of output-stationary GEMM tiles and drives the controller's state input (IDLE/STEADY/DRAIN). It also supplies the per-tile top/left SRAM read windows and watches the datapath's down-valid to tell when each tile has drained. The host sees a start pulse, busy, a done pulse and a sticky error flag.

---
 rtl/sa_tile_sequencer_if.sv | 38 +++
 rtl/sa_tile_sequencer.sv | 169 ++++++++++++++++
 tb/tb_sa_tile_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_tile_sequencer_if.sv
// Host/controller-facing signal bundle of the tile sequencer.
// slave is the sequencer side, master is the host/datapath side.
interface sa_tile_sequencer_if #(
    parameter int NUM_COL              = 8,
    parameter int LOG2_SRAM_BANK_DEPTH = 10,
    parameter int CTRL_WIDTH           = 4,
    parameter int TILE_CNT_WIDTH       = 8
);
    logic                            i_start;
    logic [TILE_CNT_WIDTH-1:0]       i_num_tiles;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_k_len;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_base_addr;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_base_addr;
    logic [NUM_COL-1:0]              i_sa_valid_down;
    logic [CTRL_WIDTH-1:0]           o_ctrl_state;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr;
    logic [TILE_CNT_WIDTH-1:0]       o_tile_idx;
    logic                            o_busy;
    logic                            o_done;
    logic                            o_err;

    modport slave (
        input  i_start, i_num_tiles, i_k_len, i_top_base_addr, i_left_base_addr, i_sa_valid_down,
        output o_ctrl_state, o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
               o_left_sram_rd_start_addr, o_left_sram_rd_end_addr, o_tile_idx,
               o_busy, o_done, o_err
    );

    modport master (
        output i_start, i_num_tiles, i_k_len, i_top_base_addr, i_left_base_addr, i_sa_valid_down,
        input  o_ctrl_state, o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
               o_left_sram_rd_start_addr, o_left_sram_rd_end_addr, o_tile_idx,
               o_busy, o_done, o_err
    );
endinterface

// File: rtl/sa_tile_sequencer.sv
// Walks a programmed number of output-stationary GEMM tiles, driving the systolic
// array controller state and per-tile SRAM read windows, with drain timeout detection.
module sa_tile_sequencer #(
    parameter int NUM_ROW              = 8,
    parameter int NUM_COL              = 8,
    parameter int LOG2_SRAM_BANK_DEPTH = 10,
    parameter int CTRL_WIDTH           = 4,
    parameter int TILE_CNT_WIDTH       = 8
) (
    input logic                clk,
    input logic                rst,
    sa_tile_sequencer_if.slave bus
);
    localparam int ADDR_W   = LOG2_SRAM_BANK_DEPTH;
    localparam int SKEW     = NUM_ROW + NUM_COL;
    localparam int TO_LIMIT = 4 * SKEW;
    localparam int CYC_W    = $clog2((1 << ADDR_W) + SKEW);
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam int BEAT_W   = $clog2(NUM_ROW + 1);

    localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE   = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] CTRL_STEADY = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] CTRL_DRAIN  = CTRL_WIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STEADY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                    state_r;
    logic [CTRL_WIDTH-1:0]     ctrl_state_r;
    logic [TILE_CNT_WIDTH-1:0] num_tiles_r;
    logic [ADDR_W-1:0]         k_len_r;
    logic [ADDR_W-1:0]         top_start_r;
    logic [ADDR_W-1:0]         top_end_r;
    logic [ADDR_W-1:0]         left_start_r;
    logic [ADDR_W-1:0]         left_end_r;
    logic [TILE_CNT_WIDTH-1:0] tile_idx_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      err_r;
    logic [CYC_W-1:0]          cyc_cnt_r;
    logic [BEAT_W-1:0]         beat_cnt_r;
    logic [TO_W-1:0]           to_cnt_r;

    logic              cfg_bad_s;
    logic              beat_hit_s;
    logic              beats_done_s;
    logic              timeout_s;
    logic              last_tile_s;
    logic [CYC_W-1:0]  steady_last_s;
    logic              unused_valid_s;

    // Only the last column's down-valid marks a completed output row.
    assign beat_hit_s     = bus.i_sa_valid_down[NUM_COL-1];
    assign unused_valid_s = ^bus.i_sa_valid_down;
    assign cfg_bad_s      = (bus.i_num_tiles == TILE_CNT_WIDTH'(0)) || (bus.i_k_len == ADDR_W'(0));
    assign beats_done_s   = beat_hit_s && (beat_cnt_r == BEAT_W'(NUM_ROW - 1));
    assign timeout_s      = (to_cnt_r == TO_W'(TO_LIMIT - 1));
    assign last_tile_s    = (tile_idx_r == (num_tiles_r - TILE_CNT_WIDTH'(1)));
    assign steady_last_s  = CYC_W'(k_len_r) + CYC_W'(SKEW - 1);

    // Tile sequencing FSM; all host and controller outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            ctrl_state_r <= CTRL_IDLE;
            num_tiles_r  <= TILE_CNT_WIDTH'(0);
            k_len_r      <= ADDR_W'(0);
            top_start_r  <= ADDR_W'(0);
            top_end_r    <= ADDR_W'(0);
            left_start_r <= ADDR_W'(0);
            left_end_r   <= ADDR_W'(0);
            tile_idx_r   <= TILE_CNT_WIDTH'(0);
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cyc_cnt_r    <= CYC_W'(0);
            beat_cnt_r   <= BEAT_W'(0);
            to_cnt_r     <= TO_W'(0);
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.i_start) begin
                        num_tiles_r <= bus.i_num_tiles;
                        k_len_r     <= bus.i_k_len;
                        busy_r      <= 1'b1;
                        if (cfg_bad_s) begin
                            err_r   <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            err_r        <= 1'b0;
                            tile_idx_r   <= TILE_CNT_WIDTH'(0);
                            top_start_r  <= bus.i_top_base_addr;
                            top_end_r    <= bus.i_top_base_addr + bus.i_k_len;
                            left_start_r <= bus.i_left_base_addr;
                            left_end_r   <= bus.i_left_base_addr + bus.i_k_len;
                            state_r      <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    cyc_cnt_r    <= CYC_W'(0);
                    ctrl_state_r <= CTRL_STEADY;
                    state_r      <= S_STEADY;
                end
                S_STEADY: begin
                    if (cyc_cnt_r == steady_last_s) begin
                        beat_cnt_r   <= BEAT_W'(0);
                        to_cnt_r     <= TO_W'(0);
                        ctrl_state_r <= CTRL_DRAIN;
                        state_r      <= S_DRAIN;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                    end
                end
                S_DRAIN: begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                    if (beat_hit_s) begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                    end
                    // A timeout still advances the sequence so the run always completes.
                    if (beats_done_s || timeout_s) begin
                        ctrl_state_r <= CTRL_IDLE;
                        if (!beats_done_s) begin
                            err_r <= 1'b1;
                        end
                        if (last_tile_s) begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            tile_idx_r   <= tile_idx_r + TILE_CNT_WIDTH'(1);
                            top_start_r  <= top_start_r + k_len_r;
                            top_end_r    <= top_end_r + k_len_r;
                            left_start_r <= left_start_r + k_len_r;
                            left_end_r   <= left_end_r + k_len_r;
                            state_r      <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    ctrl_state_r <= CTRL_IDLE;
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ctrl_state              = ctrl_state_r;
    assign bus.o_top_sram_rd_start_addr  = top_start_r;
    assign bus.o_top_sram_rd_end_addr    = top_end_r;
    assign bus.o_left_sram_rd_start_addr = left_start_r;
    assign bus.o_left_sram_rd_end_addr   = left_end_r;
    assign bus.o_tile_idx                = tile_idx_r;
    assign bus.o_busy                    = busy_r;
    assign bus.o_done                    = done_r;
    assign bus.o_err                     = err_r;
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Scoreboard bench for sa_tile_sequencer: directed runs push expected tile/done records,
// a negedge monitor reconstructs tiles from the DUT outputs and compares them.
module tb_sa_tile_sequencer;
    localparam int NR = 8;
    localparam int NC = 8;
    localparam int CW = 4;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    int   drain_delay;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sa_tile_sequencer_if #(.NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(10), .CTRL_WIDTH(CW), .TILE_CNT_WIDTH(TW)) bus_a ();
    sa_tile_sequencer_if #(.NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(4),  .CTRL_WIDTH(CW), .TILE_CNT_WIDTH(TW)) bus_b ();

    sa_tile_sequencer #(.NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(10), .CTRL_WIDTH(CW), .TILE_CNT_WIDTH(TW))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sa_tile_sequencer #(.NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(4), .CTRL_WIDTH(CW), .TILE_CNT_WIDTH(TW))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Observed view of whichever DUT is under test.
    logic [CW-1:0] m_ctrl;
    logic [9:0]    m_ts, m_te, m_ls, m_le;
    logic [TW-1:0] m_idx;
    logic          m_busy, m_done, m_err;
    assign m_ctrl = sel ? bus_b.o_ctrl_state : bus_a.o_ctrl_state;
    assign m_ts   = sel ? {6'd0, bus_b.o_top_sram_rd_start_addr}  : bus_a.o_top_sram_rd_start_addr;
    assign m_te   = sel ? {6'd0, bus_b.o_top_sram_rd_end_addr}    : bus_a.o_top_sram_rd_end_addr;
    assign m_ls   = sel ? {6'd0, bus_b.o_left_sram_rd_start_addr} : bus_a.o_left_sram_rd_start_addr;
    assign m_le   = sel ? {6'd0, bus_b.o_left_sram_rd_end_addr}   : bus_a.o_left_sram_rd_end_addr;
    assign m_idx  = sel ? bus_b.o_tile_idx : bus_a.o_tile_idx;
    assign m_busy = sel ? bus_b.o_busy : bus_a.o_busy;
    assign m_done = sel ? bus_b.o_done : bus_a.o_done;
    assign m_err  = sel ? bus_b.o_err  : bus_a.o_err;

    typedef struct {
        bit is_done;
        int idx, ts, te, ls, le, steady, drain, err;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_tile(int idx, int ts, int te, int ls, int le, int st, int dr, int er);
        exp_t e;
        e.is_done = 1'b0; e.idx = idx; e.ts = ts; e.te = te; e.ls = ls; e.le = le;
        e.steady = st; e.drain = dr; e.err = er;
        q.push_back(e);
    endfunction

    function automatic void push_done(int er);
        exp_t e;
        e = '{default: 0};
        e.is_done = 1'b1; e.err = er;
        q.push_back(e);
    endfunction

    // Valid-down driver: NR beats starting drain_delay cycles into each DRAIN.
    initial begin
        int dc;
        bit vd;
        dc = 0;
        bus_a.i_sa_valid_down = 8'h00;
        bus_b.i_sa_valid_down = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && m_ctrl == 4'd3) begin
                vd = (dc >= drain_delay) && (dc < drain_delay + NR);
                dc++;
            end else begin
                vd = 1'b0;
                dc = 0;
            end
            bus_a.i_sa_valid_down = vd ? 8'h80 : 8'h00;
            bus_b.i_sa_valid_down = vd ? 8'h80 : 8'h00;
        end
    end

    int prev_ctrl = 0, load_n = 0, steady_n = 0, drain_n = 0, cap_load = 0;
    int cap_idx = 0, cap_ts = 0, cap_te = 0, cap_ls = 0, cap_le = 0;
    bit prev_done = 1'b0, stable = 1'b1;

    // Monitor: rebuild each tile from the outputs and pop the scoreboard on tile end / done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ctrl = 0; prev_done = 1'b0; load_n = 0; steady_n = 0; drain_n = 0;
            end else begin
                if (prev_ctrl == 3 && m_ctrl != 4'd3) begin
                    if (q.size() == 0) check("tile_unexpected", q.size(), 1);
                    else begin
                        e = q.pop_front();
                        check("tile_kind", e.is_done, 0);
                        check("tile_idx", cap_idx, e.idx);
                        check("top_start", cap_ts, e.ts);
                        check("top_end", cap_te, e.te);
                        check("left_start", cap_ls, e.ls);
                        check("left_end", cap_le, e.le);
                        check("load_cycles", cap_load, 1);
                        check("steady_cycles", steady_n, e.steady);
                        check("drain_cycles", drain_n, e.drain);
                        check("window_stable", stable, 1);
                        check("err_after_tile", m_err, e.err);
                    end
                end
                if (m_done) begin
                    if (q.size() == 0) check("done_unexpected", q.size(), 1);
                    else begin
                        e = q.pop_front();
                        check("done_kind", e.is_done, 1);
                        check("done_err", m_err, e.err);
                        check("done_ctrl", m_ctrl, 0);
                        check("done_width", prev_done, 0);
                    end
                end
                if (m_busy && m_ctrl == 4'd0 && !m_done) begin
                    load_n++;
                    cap_idx = m_idx; cap_ts = m_ts; cap_te = m_te; cap_ls = m_ls; cap_le = m_le;
                    stable = 1'b1;
                end else if (m_ctrl == 4'd1 || m_ctrl == 4'd3) begin
                    if (m_ctrl == 4'd1 && prev_ctrl != 1) begin
                        cap_load = load_n; load_n = 0; steady_n = 0;
                    end
                    if (m_ctrl == 4'd3 && prev_ctrl != 3) drain_n = 0;
                    if (m_ctrl == 4'd1) steady_n++;
                    else drain_n++;
                    if (m_idx != cap_idx || m_ts != cap_ts || m_te != cap_te || m_ls != cap_ls || m_le != cap_le)
                        stable = 1'b0;
                end
                prev_ctrl = m_ctrl;
                prev_done = m_done;
            end
        end
    end

    task automatic set_cfg(input int n, input int k, input logic [9:0] tb, input logic [9:0] lb);
        bus_a.i_num_tiles = n[7:0];  bus_b.i_num_tiles = n[7:0];
        bus_a.i_k_len = k[9:0];      bus_b.i_k_len = k[3:0];
        bus_a.i_top_base_addr = tb;  bus_b.i_top_base_addr = tb[3:0];
        bus_a.i_left_base_addr = lb; bus_b.i_left_base_addr = lb[3:0];
    endtask

    task automatic do_start(input bit bad_cfg);
        @(negedge clk);
        if (sel) bus_b.i_start = 1'b1;
        else     bus_a.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.i_start = 1'b0;
        bus_b.i_start = 1'b0;
        if (bad_cfg) begin
            check("cfgerr_done_e1", m_done, 1);
            check("cfgerr_err_e1", m_err, 1);
            check("cfgerr_ctrl_e1", m_ctrl, 0);
            @(posedge clk);
            #1;
            check("cfgerr_idle_e2", m_busy, 0);
        end else begin
            check("start_busy_e1", m_busy, 1);
            check("start_ctrl_e1", m_ctrl, 0);
            check("start_err_clr", m_err, 0);
            @(posedge clk);
            #1;
            check("start_ctrl_e2", m_ctrl, 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("run_finished", n < 500, 1);
        @(negedge clk);
        check("sb_drained", q.size(), 0);
    endtask

    task automatic wait_ctrl(input int val);
        int n;
        n = 0;
        while (m_ctrl != val[CW-1:0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_ctrl", n < 200, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, m_ctrl, 0);
        check({tag, "_addr"}, m_ts | m_te | m_ls | m_le, 0);
        check({tag, "_idx"}, m_idx, 0);
        check({tag, "_flags"}, {m_busy, m_done, m_err}, 0);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; drain_delay = 0;
        bus_a.i_start = 1'b0; bus_b.i_start = 1'b0;
        set_cfg(0, 0, 10'd0, 10'd0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rst = 1'b0;

        // single tile, beats start 3 cycles into DRAIN
        set_cfg(1, 4, 10'd0, 10'd0);
        drain_delay = 3;
        push_tile(0, 0, 4, 0, 4, 20, 11, 0);
        push_done(0);
        do_start(1'b0);
        wait_idle();

        // three tiles with advancing windows
        set_cfg(3, 5, 10'd10, 10'd100);
        drain_delay = 0;
        push_tile(0, 10, 15, 100, 105, 21, 8, 0);
        push_tile(1, 15, 20, 105, 110, 21, 8, 0);
        push_tile(2, 20, 25, 110, 115, 21, 8, 0);
        push_done(0);
        do_start(1'b0);
        wait_idle();

        // config errors
        set_cfg(0, 4, 10'd0, 10'd0);
        push_done(1);
        do_start(1'b1);
        wait_idle();
        set_cfg(2, 0, 10'd0, 10'd0);
        push_done(1);
        do_start(1'b1);
        wait_idle();

        // drain timeout: no beats at all
        set_cfg(1, 2, 10'd5, 10'd7);
        drain_delay = 255;
        push_tile(0, 5, 7, 7, 9, 18, 64, 1);
        push_done(1);
        do_start(1'b0);
        wait_idle();

        // start re-pulsed mid-STEADY with a different config is ignored
        set_cfg(1, 4, 10'd32, 10'd64);
        drain_delay = 0;
        push_tile(0, 32, 36, 64, 68, 20, 8, 0);
        push_done(0);
        do_start(1'b0);
        repeat (5) @(negedge clk);
        set_cfg(3, 7, 10'd80, 10'd96);
        bus_a.i_start = 1'b1;
        @(negedge clk);
        bus_a.i_start = 1'b0;
        wait_idle();

        // reset mid-DRAIN: everything clears at once, no done
        set_cfg(2, 4, 10'd200, 10'd300);
        drain_delay = 3;
        do_start(1'b0);
        wait_ctrl(3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_stays_idle", m_busy, 0);
        check("midrst_sb", q.size(), 0);

        // 4-bit address space: top window wraps on tile 0
        sel = 1'b1;
        set_cfg(2, 4, 10'd14, 10'd0);
        drain_delay = 0;
        push_tile(0, 14, 2, 0, 4, 20, 8, 0);
        push_tile(1, 2, 6, 4, 8, 20, 8, 0);
        push_done(0);
        do_start(1'b0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
